// File: rtl/fp_add_pkg.sv
// Shared widths, IEEE constants and FSM state type for the sequenced FP adder.
package fp_add_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MENT_WIDTH = 23;
  localparam int unsigned EXPO_WIDTH = 8;
  localparam int unsigned MANT_W     = MENT_WIDTH + 1;
  localparam int unsigned SUM_W      = MENT_WIDTH + 2;
  localparam int unsigned LZC_W      = 5;
  localparam int unsigned EXPN_W     = EXPO_WIDTH + 2;
  localparam int unsigned BIAS       = 2 ** (EXPO_WIDTH - 1) - 1;
  localparam int unsigned EXP_MAX    = 2 ** EXPO_WIDTH - 1;

  localparam logic [DATA_WIDTH-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [DATA_WIDTH-1:0] INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_e;

endpackage

// File: rtl/fp_lead_one_detect.sv
// Combinational priority encoder: leading-zero count of a 25-bit sum plus all-zero flag.
module fp_lead_one_detect
  import fp_add_pkg::*;
(
  input  logic [SUM_W-1:0] vec_i,
  output logic [LZC_W-1:0] lzc_o,
  output logic             zero_o
);

  // Ascending scan: the highest set bit is the last one to write lzc_o.
  always_comb begin
    lzc_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i < SUM_W; i++) begin
      if (vec_i[i]) begin
        lzc_o  = LZC_W'(SUM_W - 1 - i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle single-precision adder: ALIGN -> ADD -> NORM over a shared datapath,
// special operands resolved at capture, result held under a valid/ready handshake.
module fp_add_sequencer
  import fp_add_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  input  logic [DATA_WIDTH-1:0] floating1_in,
  input  logic [DATA_WIDTH-1:0] floating2_in,
  input  logic                  sub_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  busy_out
);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic                    sign_l_q;
  logic                    eff_sub_q;
  logic [EXPO_WIDTH-1:0]   exp_l_q;
  logic [MANT_W-1:0]       mant_l_q;
  logic [MANT_W-1:0]       mant_s_q;
  logic [SUM_W-1:0]        sum_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    out_valid_q;
  logic                    in_ready_q;
  logic                    busy_q;

  logic [DATA_WIDTH-1:0]   b_eff;
  logic                    spec_hit;
  logic [DATA_WIDTH-1:0]   spec_res;
  logic [DATA_WIDTH-1:0]   op_l;
  logic [DATA_WIDTH-1:0]   op_s;
  logic [EXPO_WIDTH-1:0]   exp_diff;
  logic [MANT_W-1:0]       mant_s_d;
  logic [SUM_W-1:0]        sum_d;
  logic [LZC_W-1:0]        lzc;
  logic                    sum_zero;
  logic [EXPN_W-1:0]       exp_new;
  logic [MENT_WIDTH-1:0]   frac_new;
  logic [DATA_WIDTH-1:0]   norm_res;

  assign b_eff = {floating2_in[DATA_WIDTH-1] ^ sub_in, floating2_in[DATA_WIDTH-2:0]};

  // Special operands, in priority order: NaN / inf-inf, single inf, flushed zeros.
  always_comb begin
    logic                  sa, sb, ea_max, eb_max, ea_zero, eb_zero, fa_zero, fb_zero;
    sa       = floating1_in[DATA_WIDTH-1];
    sb       = b_eff[DATA_WIDTH-1];
    ea_max   = floating1_in[DATA_WIDTH-2:MENT_WIDTH] == EXPO_WIDTH'(EXP_MAX);
    eb_max   = b_eff[DATA_WIDTH-2:MENT_WIDTH] == EXPO_WIDTH'(EXP_MAX);
    ea_zero  = floating1_in[DATA_WIDTH-2:MENT_WIDTH] == '0;
    eb_zero  = b_eff[DATA_WIDTH-2:MENT_WIDTH] == '0;
    fa_zero  = floating1_in[MENT_WIDTH-1:0] == '0;
    fb_zero  = b_eff[MENT_WIDTH-1:0] == '0;
    spec_hit = 1'b1;
    spec_res = '0;
    if ((ea_max && !fa_zero) || (eb_max && !fb_zero) ||
        (ea_max && eb_max && (sa != sb))) begin
      spec_res = QNAN;
    end else if (ea_max) begin
      spec_res = floating1_in;
    end else if (eb_max) begin
      spec_res = b_eff;
    end else if (ea_zero && eb_zero) begin
      spec_res = {sa & sb, (DATA_WIDTH-1)'(0)};
    end else if (ea_zero) begin
      spec_res = b_eff;
    end else if (eb_zero) begin
      spec_res = floating1_in;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Magnitude compare on {exp,frac} decides which operand leads.
  always_comb begin
    if (a_q[DATA_WIDTH-2:0] >= b_q[DATA_WIDTH-2:0]) begin
      op_l = a_q;
      op_s = b_q;
    end else begin
      op_l = b_q;
      op_s = a_q;
    end
    exp_diff = op_l[DATA_WIDTH-2:MENT_WIDTH] - op_s[DATA_WIDTH-2:MENT_WIDTH];
    if (exp_diff >= EXPO_WIDTH'(SUM_W)) begin
      mant_s_d = '0;
    end else begin
      mant_s_d = {1'b1, op_s[MENT_WIDTH-1:0]} >> exp_diff;
    end
  end

  assign sum_d = eff_sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                           : ({1'b0, mant_l_q} + {1'b0, mant_s_q});

  fp_lead_one_detect u_lod (
    .vec_i  (sum_q),
    .lzc_o  (lzc),
    .zero_o (sum_zero)
  );

  // Leading one lands on bit 24 after the shift; a carry gives lzc=0, i.e. exp+1.
  always_comb begin
    exp_new  = EXPN_W'(exp_l_q) + EXPN_W'(1) - EXPN_W'(lzc);
    frac_new = MENT_WIDTH'((sum_q << lzc) >> 1);
    if (sum_zero) begin
      norm_res = '0;
    end else if (exp_new[EXPN_W-1] || (exp_new == '0)) begin
      norm_res = {sign_l_q, (DATA_WIDTH-1)'(0)};
    end else if (exp_new >= EXPN_W'(EXP_MAX)) begin
      norm_res = {sign_l_q, INF[DATA_WIDTH-2:0]};
    end else begin
      norm_res = {sign_l_q, exp_new[EXPO_WIDTH-1:0], frac_new};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_l_q    <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_l_q     <= '0;
      mant_l_q    <= '0;
      mant_s_q    <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_in) begin
            a_q        <= floating1_in;
            b_q        <= b_eff;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (spec_hit) begin
              result_q <= spec_res;
              state_q  <= DONE;
            end else begin
              state_q  <= ALIGN;
            end
          end
        end
        ALIGN: begin
          sign_l_q  <= op_l[DATA_WIDTH-1];
          eff_sub_q <= a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1];
          exp_l_q   <= op_l[DATA_WIDTH-2:MENT_WIDTH];
          mant_l_q  <= {1'b1, op_l[MENT_WIDTH-1:0]};
          mant_s_q  <= mant_s_d;
          state_q   <= ADD;
        end
        ADD: begin
          sum_q   <= sum_d;
          state_q <= NORM;
        end
        NORM: begin
          result_q <= norm_res;
          state_q  <= DONE;
        end
        DONE: begin
          // Valid rises one cycle after entry; acceptance only counts once it is up.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready_in) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_out  = in_ready_q;
  assign out_valid_out = out_valid_q;
  assign result_out    = result_q;
  assign busy_out      = busy_q;

endmodule
